// File: rtl/counter_mux_mod.sv
// Modulo-N up/down counter with synchronous load, wrap/saturate boundary mode,
// a registered terminal-count pulse and a sticky overflow flag.
module counter_mux_mod #(
   parameter int          WIDTH   = 4,
   parameter int unsigned MAX_VAL = 15,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
   localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

   // Boundaries are detected by explicit compares against MAX_Q and zero, so a
   // full-range MAX_VAL never leans on natural binary rollover. The ovf set is
   // written after the clear, which lets a same-edge set win over ovf_clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q   <= RST_Q;
         tc  <= 1'b0;
         ovf <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (ovf_clr)
            ovf <= 1'b0;
         if (load) begin
            q <= (load_val > MAX_Q) ? MAX_Q : load_val;
         end else if (en) begin
            if (up_dn) begin
               if (q == MAX_Q) begin
                  ovf <= 1'b1;
                  if (!sat_mode) begin
                     q  <= '0;
                     tc <= 1'b1;
                  end
               end else begin
                  q <= q + ONE_Q;
               end
            end else begin
               if (q == '0) begin
                  ovf <= 1'b1;
                  if (!sat_mode) begin
                     q  <= MAX_Q;
                     tc <= 1'b1;
                  end
               end else begin
                  q <= q - ONE_Q;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_mux_mod.sv
// Scoreboard bench for counter_mux_mod: a default 4-bit/mod-16 instance and a
// 5-bit/mod-10 instance driven by directed vectors with hand-computed results.
module tb_counter_mux_mod;

   logic       clk;
   logic       reset;

   logic       en0, up_dn0, sat_mode0, load0, ovf_clr0;
   logic [3:0] load_val0;
   logic [3:0] q0;
   logic       tc0, ovf0;

   logic       en1, up_dn1, sat_mode1, load1, ovf_clr1;
   logic [4:0] load_val1;
   logic [4:0] q1;
   logic       tc1, ovf1;

   typedef struct {
      int         sel;
      logic [4:0] q;
      logic       tc;
      logic       ovf;
      string      name;
   } exp_t;

   exp_t expq[$];
   int   vectors;
   int   miscompares;

   counter_mux_mod dut0 (
      .clk(clk), .reset(reset), .en(en0), .up_dn(up_dn0), .sat_mode(sat_mode0),
      .load(load0), .load_val(load_val0), .ovf_clr(ovf_clr0),
      .q(q0), .tc(tc0), .ovf(ovf0)
   );

   counter_mux_mod #(.WIDTH(5), .MAX_VAL(9), .RST_VAL(0)) dut1 (
      .clk(clk), .reset(reset), .en(en1), .up_dn(up_dn1), .sat_mode(sat_mode1),
      .load(load1), .load_val(load_val1), .ovf_clr(ovf_clr1),
      .q(q1), .tc(tc1), .ovf(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [4:0] aq, input logic atc,
                              input logic aovf, input logic [4:0] eq, input logic etc,
                              input logic eovf);
      vectors++;
      if (aq !== eq || atc !== etc || aovf !== eovf) begin
         miscompares++;
         $display("[TB] FAIL %s: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%b ovf=%b",
                  name, aq, atc, aovf, eq, etc, eovf);
      end
   endtask

   task automatic idleInputs();
      en0 = 0; up_dn0 = 0; sat_mode0 = 0; load0 = 0; ovf_clr0 = 0; load_val0 = '0;
      en1 = 0; up_dn1 = 0; sat_mode1 = 0; load1 = 0; ovf_clr1 = 0; load_val1 = '0;
   endtask

   // Drive one cycle of controls on the falling edge and queue the state the
   // selected counter must show after the following rising edge.
   task automatic applyStimulus(input string name, input int sel, input logic en,
                                input logic up, input logic sat, input logic ld,
                                input int lv, input logic clr, input int eq,
                                input logic etc, input logic eovf);
      exp_t e;
      @(negedge clk);
      idleInputs();
      if (sel == 0) begin
         en0 = en; up_dn0 = up; sat_mode0 = sat; load0 = ld; ovf_clr0 = clr;
         load_val0 = 4'(lv);
      end else begin
         en1 = en; up_dn1 = up; sat_mode1 = sat; load1 = ld; ovf_clr1 = clr;
         load_val1 = 5'(lv);
      end
      e.sel = sel; e.q = 5'(eq); e.tc = etc; e.ovf = eovf; e.name = name;
      expq.push_back(e);
   endtask

   // Monitor: every rising edge presents a new state; compare it against the
   // oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.sel == 0)
               checkOutput(e.name, {1'b0, q0}, tc0, ovf0, e.q, e.tc, e.ovf);
            else
               checkOutput(e.name, q1, tc1, ovf1, e.q, e.tc, e.ovf);
         end
      end
   end

   initial begin
      int wait_cycles;
      vectors = 0;
      miscompares = 0;
      idleInputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset0", {1'b0, q0}, tc0, ovf0, 5'd0, 1'b0, 1'b0);
      checkOutput("reset1", q1, tc1, ovf1, 5'd0, 1'b0, 1'b0);
      reset = 1'b1;

      // Wrap-mode up count through MAX_VAL=15.
      for (int i = 1; i <= 20; i++)
         applyStimulus("up_wrap16", 0, 1, 1, 0, 0, 0, 0, i % 16, i == 16, i >= 16);

      // Mod-10 down count from 0, wrapping twice to 9.
      for (int i = 1; i <= 11; i++)
         applyStimulus("down_wrap10", 1, 1, 0, 0, 0, 0, 0, (10 - (i % 10)) % 10,
                       (i == 1) || (i == 11), 1);
      applyStimulus("clr_idle10", 1, 0, 0, 0, 0, 0, 1, 9, 0, 0);

      // Saturating up and down counts.
      applyStimulus("clr_idle16", 0, 0, 0, 1, 0, 0, 1, 4, 0, 0);
      applyStimulus("sat_load14", 0, 0, 0, 1, 1, 14, 0, 14, 0, 0);
      applyStimulus("sat_up1", 0, 1, 1, 1, 0, 0, 0, 15, 0, 0);
      applyStimulus("sat_up2", 0, 1, 1, 1, 0, 0, 0, 15, 0, 1);
      applyStimulus("sat_up3", 0, 1, 1, 1, 0, 0, 0, 15, 0, 1);
      applyStimulus("sat_up4", 0, 1, 1, 1, 0, 0, 0, 15, 0, 1);
      applyStimulus("sat_clr", 0, 0, 1, 1, 0, 0, 1, 15, 0, 0);
      applyStimulus("sat_load1", 0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
      applyStimulus("sat_dn1", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus("sat_dn2", 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);

      // Load clamping and load-over-enable priority on the 5-bit instance.
      applyStimulus("load3", 1, 0, 0, 0, 1, 3, 0, 3, 0, 0);
      applyStimulus("load_clamp", 1, 1, 1, 0, 1, 20, 0, 9, 0, 0);
      applyStimulus("wrap_after_clamp", 1, 1, 1, 0, 0, 0, 0, 0, 1, 1);

      // Same-edge set beats clear; a later idle clear takes effect.
      applyStimulus("clr_idle_a", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus("load9", 1, 0, 0, 0, 1, 9, 0, 9, 0, 0);
      applyStimulus("set_beats_clr", 1, 1, 1, 0, 0, 0, 1, 0, 1, 1);
      applyStimulus("clr_idle_b", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // ovf is left untouched by a load.
      applyStimulus("load7_keep_ovf", 0, 0, 0, 0, 1, 7, 0, 7, 0, 1);

      // Asynchronous reset asserted between clock edges.
      @(posedge clk);
      #3;
      idleInputs();
      reset = 1'b0;
      #1;
      checkOutput("async_reset0", {1'b0, q0}, tc0, ovf0, 5'd0, 1'b0, 1'b0);
      checkOutput("async_reset1", q1, tc1, ovf1, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus("resume1", 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus("resume2", 0, 1, 1, 0, 0, 0, 0, 2, 0, 0);

      @(negedge clk);
      idleInputs();
      wait_cycles = 0;
      while (expq.size() > 0 && wait_cycles < 100) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (expq.size() > 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
